// File: rtl/async_arb_pkg.sv
// Shared definitions for the round-robin req/ack arbiter: FSM state encodings
// and the grant-index width helper.
package async_arb_pkg;

    typedef logic [1:0] arb_state_t;

    localparam arb_state_t IDLE  = 2'd0;
    localparam arb_state_t FETCH = 2'd1;
    localparam arb_state_t HOLD  = 2'd2;

    // Index width for n sources, never narrower than one bit.
    function automatic int unsigned id_bits(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/async_rr_pick.sv
// Rotating priority encoder: returns the first set bit of mask searching
// ptr+1, ptr+2, ... modulo num_src.
module async_rr_pick
    import async_arb_pkg::*;
#(
    parameter int unsigned num_src  = 4,
    parameter int unsigned id_width = id_bits(num_src)
) (
    input  logic [num_src-1:0]  mask,
    input  logic [id_width-1:0] ptr,
    output logic                found,
    output logic [id_width-1:0] idx
);

    int unsigned        cand;
    logic [num_src-1:0] mask_sh;

    // Walk offsets from farthest to nearest so the nearest hit wins.
    always_comb begin
        found   = 1'b0;
        idx     = '0;
        cand    = 0;
        mask_sh = '0;
        for (int unsigned k = num_src; k >= 1; k--) begin
            cand    = (32'(ptr) + k) % num_src;
            mask_sh = mask >> cand;
            if (mask_sh[0]) begin
                found = 1'b1;
                idx   = id_width'(cand);
            end
        end
    end

endmodule

// File: rtl/async_rr_arbiter.sv
// Round-robin arbiter collecting words from num_src req/ack producers and
// offering them to one sink. Optional FETCH timeout: ASYNC_RR_ARBITER_TIMEOUT_EN.
module async_rr_arbiter
    import async_arb_pkg::*;
#(
    parameter int unsigned num_src    = 4,
    parameter int unsigned data_width = 32,
    parameter int unsigned id_width   = id_bits(num_src),
    parameter int unsigned timeout    = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    output logic [num_src-1:0]            src_req,
    input  logic [num_src-1:0]            src_ack,
    input  logic [num_src*data_width-1:0] src_din,
    input  logic [num_src-1:0]            src_en,
    input  logic                          snk_req,
    output logic                          snk_ack,
    output logic [data_width-1:0]         snk_dout,
    output logic [id_width-1:0]           grant_id,
    output logic                          busy
`ifdef ASYNC_RR_ARBITER_TIMEOUT_EN
    ,
    output logic                          timeout_flag
`endif
);

    arb_state_t            state;
    logic [id_width-1:0]   ptr;
    logic                  pick_found;
    logic [id_width-1:0]   pick_idx;
    logic                  ack_hit;
    logic [data_width-1:0] fetch_word;

    async_rr_pick #(
        .num_src (num_src),
        .id_width(id_width)
    ) u_pick (
        .mask (src_en),
        .ptr  (ptr),
        .found(pick_found),
        .idx  (pick_idx)
    );

    // src_req is one-hot on grant_id during FETCH, so this masks foreign acks.
    assign ack_hit    = |(src_ack & src_req);
    assign fetch_word = data_width'(src_din >> (32'(grant_id) * data_width));
    assign busy       = (state != IDLE);

`ifdef ASYNC_RR_ARBITER_TIMEOUT_EN
    localparam int unsigned cnt_w = $clog2(timeout) + 1;
    logic [cnt_w-1:0] cnt;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= id_width'(num_src - 1);
            src_req  <= '0;
            snk_ack  <= 1'b0;
            snk_dout <= '0;
            grant_id <= '0;
`ifdef ASYNC_RR_ARBITER_TIMEOUT_EN
            cnt          <= '0;
            timeout_flag <= 1'b0;
`endif
        end else begin
            snk_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        grant_id <= pick_idx;
                        src_req  <= num_src'(1) << pick_idx;
                        state    <= FETCH;
`ifdef ASYNC_RR_ARBITER_TIMEOUT_EN
                        cnt      <= '0;
`endif
                    end
                end
                FETCH: begin
                    if (ack_hit) begin
                        snk_dout <= fetch_word;
                        src_req  <= '0;
                        ptr      <= grant_id;
                        state    <= HOLD;
                    end
`ifdef ASYNC_RR_ARBITER_TIMEOUT_EN
                    else if (cnt == cnt_w'(timeout - 1)) begin
                        src_req      <= '0;
                        ptr          <= grant_id;
                        timeout_flag <= 1'b1;
                        state        <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
`endif
                end
                HOLD: begin
                    if (snk_req && !snk_ack) begin
                        snk_ack <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
